// File: rtl/datapath_run_ctrl.sv
// Run controller for the single-cycle datapath: streams a program into
// instruction memory, then gates the datapath update enable for run/step/halt.
module datapath_run_ctrl #(
  parameter int         IMEM_AW     = 8,
  parameter logic [5:0] HALT_OPCODE = 6'b111111,
  parameter int         CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IMEM_AW:0]   cmd_len,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               dp_en,
  output logic               dp_clr,
  input  logic [31:0]        dp_pc,
  input  logic [31:0]        dp_instr,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  output logic               busy,
  output logic [1:0]         stop_reason,
  output logic [CNT_W-1:0]   cycle_cnt
);
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_HALT = 2'd3;

  localparam logic [1:0] RSN_NONE    = 2'd0;
  localparam logic [1:0] RSN_HALT_OP = 2'd1;
  localparam logic [1:0] RSN_BP      = 2'd2;
  localparam logic [1:0] RSN_HOST    = 2'd3;

  localparam logic [IMEM_AW:0] MAX_LEN = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0] CNT_ONE = {{IMEM_AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STEP, S_STOPPED} state_t;

  state_t             state_reg, state_next;
  logic [IMEM_AW:0]   cnt_reg, cnt_next;
  logic [IMEM_AW:0]   len_reg, len_next;
  logic               we_reg, we_next;
  logic [IMEM_AW-1:0] waddr_reg, waddr_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic               clr_reg, clr_next;
  logic               busy_reg, busy_next;
  logic [1:0]         reason_reg, reason_next;
  logic [CNT_W-1:0]   cyc_reg, cyc_next;
  logic               bp_skip_reg, bp_skip_next;

  logic       halt_op_hit, bp_hit, stop_hit, halt_fire, cmd_fire, ld_fire;
  logic [1:0] hit_reason;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^dp_instr[25:0];

  assign halt_op_hit = (dp_instr[31:26] == HALT_OPCODE);
  assign bp_hit      = bp_en && (dp_pc == bp_addr) && !bp_skip_reg;
  assign stop_hit    = halt_op_hit || bp_hit;
  assign hit_reason  = halt_op_hit ? RSN_HALT_OP : RSN_BP;

  assign cmd_ready = (state_reg == S_IDLE) || (state_reg == S_STOPPED) ||
                     ((state_reg == S_RUN) && (cmd_op == OP_HALT));
  assign ld_ready  = (state_reg == S_LOAD) && (cnt_reg < len_reg);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ld_fire   = ld_valid && ld_ready;
  assign halt_fire = (state_reg == S_RUN) && cmd_valid && (cmd_op == OP_HALT);
  assign dp_en     = ((state_reg == S_RUN) || (state_reg == S_STEP)) && !stop_hit && !halt_fire;

  assign imem_we     = we_reg;
  assign imem_waddr  = waddr_reg;
  assign imem_wdata  = wdata_reg;
  assign dp_clr      = clr_reg;
  assign busy        = busy_reg;
  assign stop_reason = reason_reg;
  assign cycle_cnt   = cyc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      len_reg     <= '0;
      we_reg      <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
      clr_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      reason_reg  <= RSN_NONE;
      cyc_reg     <= '0;
      bp_skip_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      we_reg      <= we_next;
      waddr_reg   <= waddr_next;
      wdata_reg   <= wdata_next;
      clr_reg     <= clr_next;
      busy_reg    <= busy_next;
      reason_reg  <= reason_next;
      cyc_reg     <= cyc_next;
      bp_skip_reg <= bp_skip_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    we_next      = 1'b0;
    waddr_next   = waddr_reg;
    wdata_next   = wdata_reg;
    clr_next     = 1'b0;
    reason_next  = reason_reg;
    cyc_next     = cyc_reg;
    bp_skip_next = bp_skip_reg;

    if (dp_en && !(&cyc_reg)) begin
      cyc_next = cyc_reg + CNT_W'(1);
    end

    case (state_reg)
      S_IDLE, S_STOPPED: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_LOAD: begin
              if (cmd_len != '0) begin
                state_next = S_LOAD;
                cnt_next   = '0;
                len_next   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
              end
            end
            OP_RUN: begin
              state_next  = S_RUN;
              reason_next = RSN_NONE;
            end
            OP_STEP: begin
              state_next  = S_STEP;
              reason_next = RSN_NONE;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (ld_fire) begin
          we_next    = 1'b1;
          waddr_next = cnt_reg[IMEM_AW-1:0];
          wdata_next = ld_data;
          cnt_next   = cnt_reg + CNT_ONE;
        end else if (we_reg && (cnt_reg == len_reg)) begin
          // Last word has just been written: restart the datapath from PC 0.
          state_next   = S_IDLE;
          clr_next     = 1'b1;
          cyc_next     = '0;
          reason_next  = RSN_NONE;
          bp_skip_next = 1'b0;
        end
      end
      S_RUN: begin
        bp_skip_next = 1'b0;
        if (stop_hit) begin
          state_next   = S_STOPPED;
          reason_next  = hit_reason;
          bp_skip_next = !halt_op_hit;
        end else if (halt_fire) begin
          state_next  = S_STOPPED;
          reason_next = RSN_HOST;
        end
      end
      S_STEP: begin
        state_next   = S_STOPPED;
        reason_next  = stop_hit ? hit_reason : RSN_HOST;
        bp_skip_next = stop_hit && !halt_op_hit;
      end
      default: state_next = S_IDLE;
    endcase

    busy_next = (state_next == S_LOAD) || (state_next == S_RUN) || (state_next == S_STEP);
  end

endmodule

// File: doc/datapath_run_ctrl.md
Name: datapath_run_ctrl

Overview:
Run controller for the single-cycle Datapath. It loads a program into instruction memory over a valid/ready stream and then sequences execution by gating the datapath's state-update enable. It supports run, single-step, host halt, a halt opcode and one PC breakpoint, and counts executed cycles. It sits between the host/bench command interface and the Datapath plus its instruction memory.

Parameters:
IMEM_AW, 8, instruction-memory word-address width (depth 2^IMEM_AW words)
HALT_OPCODE, 6'b111111, instr[31:26] value that stops execution
CNT_W, 32, cycle counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=LOAD, 1=RUN, 2=STEP, 3=HALT
cmd_len  in  IMEM_AW+1  word count for LOAD
ld_valid  in  1  program word valid
ld_ready  out  1  program word accepted when ld_valid && ld_ready
ld_data  in  32  program word
imem_we  out  1  instruction-memory write strobe
imem_waddr  out  IMEM_AW  write word address
imem_wdata  out  32  write data
dp_en  out  1  datapath PC/regfile/dmem update enable
dp_clr  out  1  one-cycle synchronous PC clear to datapath
dp_pc  in  32  current datapath PC
dp_instr  in  32  instruction at dp_pc
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
busy  out  1  state is LOAD, RUN or STEP
stop_reason  out  2  0=none, 1=halt opcode, 2=breakpoint, 3=host halt/step done
cycle_cnt  out  CNT_W  number of cycles with dp_en=1

Behaviour:
- States: IDLE, LOAD, RUN, STEP, STOPPED.
- Reset (rst=0, async): state IDLE; dp_en=0, dp_clr=0, imem_we=0, imem_waddr=0, imem_wdata=0, ld_ready=0, busy=0, stop_reason=0, cycle_cnt=0, bp_skip=0. Reset mid-load or mid-run abandons the operation; no further imem writes occur.
- cmd_ready: 1 in IDLE and STOPPED; in RUN equals (cmd_op==HALT); 0 in LOAD and STEP.
- LOAD accepted with cmd_len=0: no-op, state unchanged. With cmd_len=N>0: next state LOAD, word counter=0. N is capped at 2^IMEM_AW.
- In LOAD, ld_ready=1. Each handshake registers imem_we=1, imem_waddr=counter and imem_wdata=ld_data on the next edge (1-cycle latency), then increments the counter. The cycle after the Nth write: dp_clr=1 for exactly one cycle, cycle_cnt=0, stop_reason=0, bp_skip=0, state IDLE.
- stop_hit (combinational) = (dp_instr[31:26]==HALT_OPCODE) || (bp_en && dp_pc==bp_addr && !bp_skip).
- dp_en (combinational) = (state==RUN || state==STEP) && !stop_hit && !(HALT handshake this cycle).
- RUN/STEP accepted from IDLE or STOPPED: next state RUN/STEP. stop_reason is cleared on entry.
- RUN: each cycle with dp_en=1 increments cycle_cnt, saturating at all-ones. On stop_hit: state STOPPED, stop_reason=1 (halt opcode takes priority) or 2. On a HALT handshake without stop_hit: STOPPED, reason 3. If stop_hit and HALT occur in the same cycle, stop_hit's reason wins.
- STEP: one cycle. If !stop_hit, dp_en=1 for that cycle, then STOPPED with reason 3. If stop_hit, dp_en=0, then STOPPED with the stop_hit reason.
- bp_skip: set on entering STOPPED with reason 2. Cleared after the first cycle of the next RUN/STEP, so execution can leave the breakpoint PC.
- Halt opcode is sticky: a RUN/STEP at a halt instruction stops after 1 cycle with dp_en=0 and reason 1.
- A LOAD accepted from STOPPED is permitted and reloads the program.
- busy registered with state.

Test Plan:
- Reset with rst=0 mid-LOAD after 2 of 4 words -> all outputs at reset values, state IDLE, no further imem_we.
- LOAD N=3 with words 0x20080005, 0x21080001, 0xFC000000 (ld_valid held high) -> imem_we at addrs 0,1,2 on consecutive cycles with matching data; dp_clr pulses once; busy drops; cmd_ready=1.
- RUN on that program -> dp_en high for exactly 2 cycles, cycle_cnt=2, stop_reason=1, state STOPPED; a second RUN gives dp_en=0 and cycle_cnt stays 2.
- bp_en=1, bp_addr=0x4, RUN from PC 0 -> stop at dp_pc=0x4 with reason 2, cycle_cnt=1; next STEP -> dp_en 1 cycle, reason 3, PC advances.
- Non-halting loop, RUN, then HALT on cycle 10 -> cmd_ready=1 for HALT only, dp_en=0 in the handshake cycle, cycle_cnt=9, reason 3.
- HALT asserted in the same cycle dp_instr hits HALT_OPCODE -> reason 1; LOAD with cmd_len=0 -> no writes, state unchanged.
